// File: rtl/mdr_operand_loader.sv
// Operand-load sequencer: steps through NUM_CH channels on the load button, then launches the MDR core.
// Optional WAIT_LOAD timeout is built when LOADER_TIMEOUT_EN is defined.
module mdr_operand_loader #(
  parameter int NUM_CH         = 2,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  localparam int CW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load,
  input  logic              clear,
  input  logic              ready,
  output logic [NUM_CH-1:0] load_led,
  output logic [NUM_CH-1:0] load_en,
  output logic [CW-1:0]     ch_idx,
  output logic              flag_start,
  output logic              busy,
  output logic              timeout
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_WAIT_LOAD = 3'd2,
    S_LOADING   = 3'd3,
    S_LAUNCH    = 3'd4,
    S_RUN       = 3'd5
  } state_t;

  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   ch_idx_q, ch_idx_d;
  logic            first_q, first_d;
  logic [NUM_CH-1:0] ch_onehot;

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic          cnt_expired;

  assign cnt_expired = (cnt_q == CNT_LAST);
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ch_idx_q <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_idx_q <= ch_idx_d;
      first_q  <= first_d;
    end
  end

  // Next-state logic; clear overrides everything outside IDLE
  always_comb begin
    state_d  = state_q;
    ch_idx_d = ch_idx_q;
    first_d  = 1'b0;
`ifdef LOADER_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    if (clear && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      ch_idx_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ch_idx_d = '0;
          if (start) begin
            state_d = S_ARM;
`ifdef LOADER_TIMEOUT_EN
            timeout_d = 1'b0;
`endif
          end
        end
        S_ARM: begin
          if (!start) begin
            state_d  = S_WAIT_LOAD;
            ch_idx_d = '0;
          end
        end
        S_WAIT_LOAD: begin
`ifdef LOADER_TIMEOUT_EN
          if (cnt_expired) begin
            state_d   = S_IDLE;
            ch_idx_d  = '0;
            timeout_d = 1'b1;
          end else if (load) begin
            state_d = S_LOADING;
            first_d = 1'b1;
          end
`else
          if (load) begin
            state_d = S_LOADING;
            first_d = 1'b1;
          end
`endif
        end
        S_LOADING: begin
          if (!load) begin
            if (ch_idx_q == LAST_CH) begin
              state_d = S_LAUNCH;
            end else begin
              state_d  = S_WAIT_LOAD;
              ch_idx_d = ch_idx_q + CW'(1);
            end
          end
        end
        S_LAUNCH: begin
          state_d = S_RUN;
        end
        S_RUN: begin
          if (ready) begin
            state_d  = S_IDLE;
            ch_idx_d = '0;
          end
        end
        default: begin
          state_d  = S_IDLE;
          ch_idx_d = '0;
        end
      endcase
    end
  end

`ifdef LOADER_TIMEOUT_EN
  // Counter restarts from zero on every entry to WAIT_LOAD
  always_comb begin
    cnt_d = '0;
    if (state_q == S_WAIT_LOAD && state_d == S_WAIT_LOAD) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_onehot
    assign ch_onehot[gi] = (ch_idx_q == CW'(gi));
  end

  // Moore outputs decoded from registered state only
  always_comb begin
    load_led   = '0;
    load_en    = '0;
    flag_start = 1'b0;
    busy       = (state_q != S_IDLE);
    ch_idx     = ch_idx_q;
    case (state_q)
      S_WAIT_LOAD: load_led   = ch_onehot;
      S_LOADING:   load_en    = first_q ? ch_onehot : '0;
      S_LAUNCH:    flag_start = 1'b1;
      default:     ;
    endcase
  end

endmodule

// File: doc/mdr_operand_loader.md
# mdr_operand_loader

Parametrised operand-load sequencer for the MDR datapath. It walks the user through loading `NUM_CH` operand channels with one push-button (`load`), then launches the operation and waits for completion. It sits between the debounced/synchronised front-panel buttons and the operand registers and MDR core start input. Behaviour beyond the fixed two-channel loader:

- N channels.
- Single-cycle load strobes.
- Synchronous abort.
- Optional operand-wait timeout.

## Interface
Parameters:
- `NUM_CH`, 2, number of operand channels (1..8).
- `TIMEOUT_CYCLES`, 50_000_000, clk cycles allowed in WAIT_LOAD before timeout (≥2; used only with `LOADER_TIMEOUT_EN`).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `start`  in  1  start button level, already synchronised and debounced.
- `load`  in  1  load button level, already synchronised and debounced.
- `clear`  in  1  synchronous abort, level.
- `ready`  in  1  MDR core done, level.
- `load_led`  out  `NUM_CH`  one-hot "channel k awaiting load" indicator.
- `load_en`  out  `NUM_CH`  one-hot single-cycle write strobe to operand register k.
- `ch_idx`  out  `$clog2(NUM_CH)` (min 1)  current channel index.
- `flag_start`  out  1  single-cycle launch pulse to MDR core.
- `busy`  out  1  high from leaving IDLE until return to IDLE.
- `timeout`  out  1  sticky timeout indicator (constant 0 without `LOADER_TIMEOUT_EN`).

## Operation
States: IDLE, ARM, WAIT_LOAD, LOADING, LAUNCH, RUN. Encoding is free; illegal states go to IDLE.

Transitions, evaluated on each rising clk edge:
- IDLE: `start`=1 → ARM; clear `timeout`.
- ARM: `start`=0 → WAIT_LOAD with `ch_idx`=0.
- WAIT_LOAD: `load`=1 → LOADING.
- LOADING: `load`=0 and `ch_idx`<`NUM_CH`-1 → WAIT_LOAD with `ch_idx`+1. `load`=0 and `ch_idx`=`NUM_CH`-1 → LAUNCH.
- LAUNCH: unconditional → RUN.
- RUN: `ready`=1 → IDLE with `ch_idx`=0.

`clear`=1 in any state other than IDLE → IDLE next edge. `clear` has priority over every other condition. No `load_en` or `flag_start` pulse is produced on the aborting edge. `ch_idx` resets to 0.

Outputs (Moore, registered or state-decoded, glitch-free):
- `load_led[ch_idx]`=1 only in WAIT_LOAD; all other bits 0.
- `load_en[ch_idx]`=1 only in the first cycle of LOADING. Holding `load` produces exactly one strobe.
- `flag_start`=1 only in LAUNCH, which always lasts exactly one cycle.
- `busy`=1 in every state except IDLE.

Other rules:
- `ready` is ignored outside RUN.
- `start` is ignored outside IDLE and ARM.
- `load` is ignored outside WAIT_LOAD and LOADING.

## Timing
- Reset (async, active-low): state IDLE, `ch_idx`=0, all outputs 0, timeout counter 0.
- `load` rising sampled at edge t (in WAIT_LOAD) → `load_en` high in cycle t+1 for exactly one cycle.
- `load` low sampled at edge t (in LOADING, last channel) → `flag_start` high in cycle t+1. `busy` stays high until the edge that samples `ready`=1.
- Minimum full sequence for `NUM_CH`=2 with 1-cycle button pulses: 1 (ARM) + 2×2 (WAIT/LOADING) + 1 (LAUNCH) + RUN cycles.
- `ready`=1 already high on entering RUN → IDLE after exactly one RUN cycle.
- Simultaneous `clear` and `ready` in RUN → IDLE; the outcome is identical either way.
- Reset asserted mid-operation → immediate IDLE. No strobe completes.

## Configuration
Macro `LOADER_TIMEOUT_EN`:
- Defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES)` runs while in WAIT_LOAD and clears on every entry to WAIT_LOAD.
  - When it reaches `TIMEOUT_CYCLES`-1, the next edge goes to IDLE and sets `timeout`=1.
  - `timeout` stays 1 until the next IDLE→ARM transition or reset.
- Undefined:
  - No counter is built; `timeout` is tied to 0.
  - WAIT_LOAD waits indefinitely.

## Test plan
- `NUM_CH`=2, start pulse, then two load pulses of 3 cycles each → `load_en` = 01 then 10, one cycle each. `flag_start` pulses once. `ready` after 5 cycles → `busy` falls and `ch_idx`=0.
- `NUM_CH`=4, load held 20 cycles per channel → exactly 4 strobes (0001, 0010, 0100, 1000). `load_led` one-hot follows `ch_idx` 0..3.
- `clear` asserted in LOADING of channel 1 → IDLE next cycle, no further `load_en`, no `flag_start`. A fresh start sequence begins at `ch_idx`=0.
- `ready` held high throughout → ignored until RUN. RUN lasts 1 cycle, and `flag_start` precedes the `busy` fall by 1 cycle.
- `LOADER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=10, no load after ARM → IDLE after 10 WAIT_LOAD cycles, `timeout`=1. Next start press clears `timeout`.
- Reset pulse asserted mid-RUN → all outputs 0 immediately (asynchronous), state IDLE.
